hazard_scheduler: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Tracks each in-flight register write (destination, Tnew, write-enable) through E/M/W shadow registers, and sequences the multi-cycle HI/LO multiply/divide unit with a busy counter. Outputs the D-stage stall, the E-stage bubble insert, and the forwarding selects for D-stage (branch/jr) and E-stage (ALU) operands. Sits beside the D/E pipeline registers, fed by the D-stage decoder and the resolved E-stage write-register select.

---
 rtl/cpu_pkg.sv | 69 ++++++
 rtl/md_busy_counter.sv | 39 +++
 rtl/hazard_scheduler.sv | 99 +++++++++
 tb/tb_hazard_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and per-stage helpers for the MIPS pipeline hazard logic.
// Holds the forwarding-select codes, Tuse/Tnew constants and the shadow-register record.
package cpu_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE  = 2'd3;
  localparam logic [1:0] TNEW_READY = 2'd0;
  localparam logic [1:0] TNEW_ALU   = 2'd1;
  localparam logic [1:0] TNEW_LOAD  = 2'd2;

  typedef struct packed {
    logic [4:0] dst;
    logic       we;
    logic [1:0] tnew;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{dst: 5'd0, we: 1'b0, tnew: 2'd0};

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == TNEW_READY) ? TNEW_READY : (t - 2'd1);
  endfunction

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic stage_match(input shadow_t s, input logic [4:0] r);
    return s.we && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic stage_ready(input shadow_t s, input logic [4:0] r);
    return stage_match(s, r) && (s.tnew == TNEW_READY);
  endfunction

  function automatic logic stage_hazard(input shadow_t s, input logic [4:0] r,
                                        input logic [1:0] tuse);
    return (tuse != TUSE_NONE) && stage_match(s, r) && (s.tnew > tuse);
  endfunction

  function automatic logic [1:0] fwd_sel_d(input shadow_t e, input shadow_t m,
                                           input shadow_t w, input logic [4:0] r);
    logic [1:0] sel;
    if (stage_ready(e, r)) begin
      sel = FWD_E;
    end else if (stage_ready(m, r)) begin
      sel = FWD_M;
    end else if (stage_ready(w, r)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input shadow_t m, input shadow_t w,
                                           input logic [4:0] r);
    logic [1:0] sel;
    if (stage_ready(m, r)) begin
      sel = FWD_M;
    end else if (stage_ready(w, r)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy tracker for the multi-cycle HI/LO unit: loads the operation latency
// when a start leaves E, then counts down; busy covers the start cycle too.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_load;
  logic             w_count_nz;

  always_comb begin
    w_load     = i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    w_count_nz = (r_count != {CNT_W{1'b0}});
    o_busy     = w_count_nz | i_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_start) begin
      r_count <= w_load;
    end else if (w_count_nz) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Stall / bubble / forwarding controller for the 5-stage MIPS core, built on
// E/M/W shadow copies of each in-flight write and the HI/LO busy counter.
module hazard_scheduler
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] dst_D,
  input  logic       we_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic       flush_E,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       md_busy
);

  shadow_t    r_E;
  shadow_t    r_M;
  shadow_t    r_W;
  logic [4:0] r_rs_E;
  logic [4:0] r_rt_E;
  logic       r_md_start_E;
  logic       r_md_div_E;

  logic w_data_stall;
  logic w_md_stall;
  logic w_stall;
  logic w_md_busy;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_md_start_E),
    .i_div   (r_md_div_E),
    .o_busy  (w_md_busy)
  );

  always_comb begin
    w_data_stall = stage_hazard(r_E, rs_D, tuse_rs_D) | stage_hazard(r_E, rt_D, tuse_rt_D)
                 | stage_hazard(r_M, rs_D, tuse_rs_D) | stage_hazard(r_M, rt_D, tuse_rt_D)
                 | stage_hazard(r_W, rs_D, tuse_rs_D) | stage_hazard(r_W, rt_D, tuse_rt_D);
    w_md_stall   = (md_use_D | md_start_D) & w_md_busy;
    w_stall      = w_data_stall | w_md_stall;

    stall    = w_stall;
    flush_E  = w_stall;
    md_busy  = w_md_busy;
    fwd_rs_D = fwd_sel_d(r_E, r_M, r_W, rs_D);
    fwd_rt_D = fwd_sel_d(r_E, r_M, r_W, rt_D);
    fwd_rs_E = fwd_sel_e(r_M, r_W, r_rs_E);
    fwd_rt_E = fwd_sel_e(r_M, r_W, r_rt_E);
  end

  // A stalled D instruction leaves a bubble in E; M and W always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_E          <= SHADOW_BUBBLE;
      r_M          <= SHADOW_BUBBLE;
      r_W          <= SHADOW_BUBBLE;
      r_rs_E       <= 5'd0;
      r_rt_E       <= 5'd0;
      r_md_start_E <= 1'b0;
      r_md_div_E   <= 1'b0;
    end else begin
      if (w_stall) begin
        r_E          <= SHADOW_BUBBLE;
        r_rs_E       <= 5'd0;
        r_rt_E       <= 5'd0;
        r_md_start_E <= 1'b0;
        r_md_div_E   <= 1'b0;
      end else begin
        r_E          <= '{dst: dst_D, we: we_D, tnew: tnew_D};
        r_rs_E       <= rs_D;
        r_rt_E       <= rt_D;
        r_md_start_E <= md_start_D;
        r_md_div_E   <= md_start_D & md_div_D;
      end
      r_M <= '{dst: r_E.dst, we: r_E.we, tnew: tnew_dec(r_E.tnew)};
      r_W <= '{dst: r_M.dst, we: r_M.we, tnew: tnew_dec(r_M.tnew)};
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: expected output vectors are queued as each
// D-stage instruction is driven and compared on the following falling edge.
module tb_hazard_scheduler;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, dst_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       we_D, md_start_D, md_div_D, md_use_D;
  logic       stall, flush_E, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [10:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;
  exp_t sbq[$];

  hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .dst_D      (dst_D),
    .we_D       (we_D),
    .tnew_D     (tnew_D),
    .md_start_D (md_start_D),
    .md_div_D   (md_div_D),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .flush_E    (flush_E),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_rs_E   (fwd_rs_E),
    .fwd_rt_E   (fwd_rt_E),
    .md_busy    (md_busy)
  );

  assign obs = {stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An operand whose producer is still unfinished in M must never reach E unstalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!((dut.r_rs_E != 5'd0 && dut.r_M.we && dut.r_M.dst == dut.r_rs_E && dut.r_M.tnew != 2'd0) ||
                (dut.r_rt_E != 5'd0 && dut.r_M.we && dut.r_M.dst == dut.r_rt_E && dut.r_M.tnew != 2'd0)))
      else begin
        bad++;
        $error("FAIL e_unready_in_m observed=1 expected=0 at %0t", $time);
      end
    end
  end

  function automatic logic [10:0] ex(input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                                     input logic [1:0] rse, input logic [1:0] rte, input logic bz);
    return {st, st, rsd, rtd, rse, rte, bz};
  endfunction

  task automatic setd(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                      input logic [1:0] trt, input logic [4:0] dst, input logic we,
                      input logic [1:0] tn);
    rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
    dst_D = dst; we_D = we; tnew_D = tn;
    md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic idle();
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic setmd(input logic st, input logic dv, input logic us);
    md_start_D = st; md_div_D = dv; md_use_D = us;
  endtask

  task automatic chk(input string tag, input logic [10:0] v);
    exp_t e;
    sbq.push_back('{tag: tag, v: v});
    @(negedge clk);
    e = sbq.pop_front();
    total++;
    assert (obs === e.v)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    setd(5'd8, 5'd8, 2'd0, 2'd0, 5'd8, 1'b1, 2'd2);
    chk("reset_state", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    rst_n = 1'b1;

    // load-use: lw $8 then addu $9,$8,$10
    setd(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);
    chk("lw_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd8, 5'd10, 2'd1, 2'd1, 5'd9, 1'b1, 2'd1);
    chk("loaduse_stall", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    chk("loaduse_release", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    idle();
    chk("loaduse_fwd_w", ex(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0));

    // ALU result consumed by a branch in D
    setd(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
    chk("addu3_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("beq_stall", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    chk("beq_fwd_m", ex(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0));

    // jal then jr $31
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0);
    chk("jal_issue_beq_fwd_w", ex(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0));
    setd(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    chk("jr_fwd_e", ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0));

    // load into $0, then a $0 reader
    setd(5'd31, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2);
    chk("lw0_issue_fwd_m", ex(1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0));
    setd(5'd0, 5'd0, 2'd0, 2'd0, 5'd5, 1'b1, 2'd1);
    chk("reg0_no_stall", ex(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0));
    idle();
    chk("quiet_1", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd0, 5'd5, 2'd3, 2'd1, 5'd0, 1'b0, 2'd0);
    chk("rt_fwd_m", ex(1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0));
    idle();
    chk("rt_fwd_e_w", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0));

    // three writers of $7 in flight: E wins over M and W
    for (int i = 0; i < 3; i++) begin
      setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 1'b1, 2'd0);
      chk("w7_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    end
    setd(5'd7, 5'd7, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("prio_e", ex(1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0));
    idle();
    chk("prio_e_stage_m", ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0));
    chk("quiet_2", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // load then rt consumer in D
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 1'b1, 2'd2);
    chk("lw6_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd0, 5'd6, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0);
    chk("rt_stall_e", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    chk("rt_stall_m", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    chk("rt_fwd_w", ex(1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b0));
    idle();
    chk("quiet_3", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // div then mflo: 1 + 10 stall cycles
    idle(); setmd(1'b1, 1'b1, 1'b0);
    chk("div_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 1'b1, 2'd1); setmd(1'b0, 1'b0, 1'b1);
    chk("div_start_e", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    end
    chk("div_release", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // mult, then a second mult while busy, then drain
    idle(); setmd(1'b1, 1'b0, 1'b0);
    chk("mult_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    chk("mult2_start_e", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      chk("mult2_busy", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    end
    chk("mult2_release", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    idle();
    chk("mult_drain_start", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      chk("mult_drain", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    end
    chk("mult_idle", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // reset while the divider count sits at 4
    idle(); setmd(1'b1, 1'b1, 1'b0);
    chk("div2_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 1'b1, 2'd1); setmd(1'b0, 1'b0, 1'b1);
    chk("div2_start_e", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      chk("div2_busy", ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    end
    rst_n = 1'b0;
    chk("rst_mid_div", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    rst_n = 1'b1;
    chk("mflo_after_rst", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    idle();
    chk("quiet_4", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    // reset clears a pending link forward
    setd(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0);
    chk("jal2_issue", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    setd(5'd31, 5'd31, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    rst_n = 1'b0;
    chk("rst_clears_fwd", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    rst_n = 1'b1;
    chk("jr_after_rst", ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
